// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two write-back sources, the arbiter and the
// register file write port.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32
) ();
    logic            A_Valid;
    logic [4:0]      A_Rd;
    logic [XLEN-1:0] A_Data;
    logic            A_Ready;

    logic            B_Valid;
    logic [4:0]      B_Rd;
    logic [XLEN-1:0] B_Data;
    logic            B_Ready;

    logic            Reg_Wr;
    logic [4:0]      Rd_Wr;
    logic [XLEN-1:0] Rd_In;
    logic            Busy;

    // Sources and register file side
    modport master (
        output A_Valid, A_Rd, A_Data,
        input  A_Ready,
        output B_Valid, B_Rd, B_Data,
        input  B_Ready,
        input  Reg_Wr, Rd_Wr, Rd_In, Busy
    );

    // Arbiter side
    modport slave (
        input  A_Valid, A_Rd, A_Data,
        output A_Ready,
        input  B_Valid, B_Rd, B_Data,
        output B_Ready,
        output Reg_Wr, Rd_Wr, Rd_In, Busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Two one-entry holding buffers (A = execute, B = memory) compete for the
// port; the older entry wins, equal-age ties alternate via last_b_q.
module regfile_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    logic            full_a_q, full_a_d;
    logic [4:0]      rd_a_q, rd_a_d;
    logic [XLEN-1:0] data_a_q, data_a_d;

    logic            full_b_q, full_b_d;
    logic [4:0]      rd_b_q, rd_b_d;
    logic [XLEN-1:0] data_b_q, data_b_d;

    // Age flags are only meaningful while both buffers are full;
    // both clear means the entries were filled on the same edge.
    logic            a_older_q, a_older_d;
    logic            b_older_q, b_older_d;
    logic            last_b_q, last_b_d;

    logic            reg_wr_q, reg_wr_d;
    logic [4:0]      rd_wr_q, rd_wr_d;
    logic [XLEN-1:0] rd_in_q, rd_in_d;

    logic            grant_a, grant_b;
    logic            acc_a, acc_b;
    logic            load_a, load_b;

    // Grant selection: a lone full buffer wins, otherwise age, then round-robin
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (full_a_q && full_b_q) begin
            if (a_older_q)      grant_a = 1'b1;
            else if (b_older_q) grant_b = 1'b1;
            else if (last_b_q)  grant_a = 1'b1;
            else                grant_b = 1'b1;
        end else if (full_a_q) begin
            grant_a = 1'b1;
        end else if (full_b_q) begin
            grant_b = 1'b1;
        end
    end

    // A draining buffer can take a new entry on the same edge
    assign bus.A_Ready = ~full_a_q | grant_a;
    assign bus.B_Ready = ~full_b_q | grant_b;

    assign acc_a  = bus.A_Valid & bus.A_Ready;
    assign acc_b  = bus.B_Valid & bus.B_Ready;
    // Writes to x0 complete the handshake but never occupy a buffer
    assign load_a = acc_a & (bus.A_Rd != 5'd0);
    assign load_b = acc_b & (bus.B_Rd != 5'd0);

    // Holding buffer next state: load on accept, clear on grant
    always_comb begin
        full_a_d = load_a | (full_a_q & ~grant_a);
        rd_a_d   = load_a ? bus.A_Rd   : rd_a_q;
        data_a_d = load_a ? bus.A_Data : data_a_q;
        full_b_d = load_b | (full_b_q & ~grant_b);
        rd_b_d   = load_b ? bus.B_Rd   : rd_b_q;
        data_b_d = load_b ? bus.B_Data : data_b_q;
    end

    // Age and round-robin pointer next state
    always_comb begin
        a_older_d = a_older_q;
        b_older_d = b_older_q;
        if (!(full_a_d && full_b_d)) begin
            a_older_d = 1'b0;
            b_older_d = 1'b0;
        end else if (load_a && load_b) begin
            a_older_d = 1'b0;
            b_older_d = 1'b0;
        end else if (load_a) begin
            a_older_d = 1'b0;
            b_older_d = 1'b1;
        end else if (load_b) begin
            a_older_d = 1'b1;
            b_older_d = 1'b0;
        end

        last_b_d = last_b_q;
        if (grant_b)      last_b_d = 1'b1;
        else if (grant_a) last_b_d = 1'b0;
    end

    // Output stage next state: address/data hold when nothing is granted
    always_comb begin
        reg_wr_d = grant_a | grant_b;
        rd_wr_d  = rd_wr_q;
        rd_in_d  = rd_in_q;
        if (grant_a) begin
            rd_wr_d = rd_a_q;
            rd_in_d = data_a_q;
        end else if (grant_b) begin
            rd_wr_d = rd_b_q;
            rd_in_d = data_b_q;
        end
    end

    // Holding buffer registers
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            full_a_q <= 1'b0;
            rd_a_q   <= '0;
            data_a_q <= '0;
            full_b_q <= 1'b0;
            rd_b_q   <= '0;
            data_b_q <= '0;
        end else begin
            full_a_q <= full_a_d;
            rd_a_q   <= rd_a_d;
            data_a_q <= data_a_d;
            full_b_q <= full_b_d;
            rd_b_q   <= rd_b_d;
            data_b_q <= data_b_d;
        end
    end

    // Arbitration state registers; A is favoured first out of reset
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            a_older_q <= 1'b0;
            b_older_q <= 1'b0;
            last_b_q  <= 1'b1;
        end else begin
            a_older_q <= a_older_d;
            b_older_q <= b_older_d;
            last_b_q  <= last_b_d;
        end
    end

    // Registered write port toward the register file
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            reg_wr_q <= 1'b0;
            rd_wr_q  <= '0;
            rd_in_q  <= '0;
        end else begin
            reg_wr_q <= reg_wr_d;
            rd_wr_q  <= rd_wr_d;
            rd_in_q  <= rd_in_d;
        end
    end

    assign bus.Reg_Wr = reg_wr_q;
    assign bus.Rd_Wr  = rd_wr_q;
    assign bus.Rd_In  = rd_in_q;
    assign bus.Busy   = full_a_q | full_b_q | reg_wr_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a cycle-by-cycle vector table for
// single/simultaneous/oldest-first/x0 cases, then streaming and reset abort.
module tb_regfile_wb_arbiter;

    logic CLK;
    logic rst_n;

    regfile_wb_arbiter_if #(.XLEN(32)) bus ();

    regfile_wb_arbiter #(.XLEN(32)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        a_v;
        logic [4:0]  a_rd;
        logic [31:0] a_d;
        logic        b_v;
        logic [4:0]  b_rd;
        logic [31:0] b_d;
        logic        e_ar;
        logic        e_br;
        logic        e_wr;
        logic [4:0]  e_rdwr;
        logic [31:0] e_rdin;
        logic        e_busy;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic a_v, input logic [4:0] a_rd, input logic [31:0] a_d,
        input logic b_v, input logic [4:0] b_rd, input logic [31:0] b_d,
        input logic e_ar, input logic e_br, input logic e_wr,
        input logic [4:0] e_rdwr, input logic [31:0] e_rdin, input logic e_busy);
        vec_t r;
        r.a_v = a_v; r.a_rd = a_rd; r.a_d = a_d;
        r.b_v = b_v; r.b_rd = b_rd; r.b_d = b_d;
        r.e_ar = e_ar; r.e_br = e_br; r.e_wr = e_wr;
        r.e_rdwr = e_rdwr; r.e_rdin = e_rdin; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.A_Valid = 1'b0; bus.A_Rd = 5'd0; bus.A_Data = 32'h0;
        bus.B_Valid = 1'b0; bus.B_Rd = 5'd0; bus.B_Data = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_cnt;
        int b_cnt;
        int w;
        logic [4:0]  exp_rd;
        logic [31:0] exp_d;

        //            a_v a_rd  a_d            b_v b_rd  b_d       ar br wr rdwr   rdin           busy
        // simultaneous fill, same Rd: A first (pointer favours A), then B
        vecs[0]  = mk(1, 5'd3,  32'h11,        1, 5'd3,  32'h22,   1, 1, 0, 5'd0,  32'h0,         0);
        vecs[1]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 0, 0, 5'd0,  32'h0,         1);
        vecs[2]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 1, 5'd3,  32'h11,        1);
        vecs[3]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 1, 5'd3,  32'h22,        1);
        vecs[4]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 0, 5'd3,  32'h22,        0);
        // single write from A
        vecs[5]  = mk(1, 5'd5,  32'hDEADBEEF,  0, 5'd0,  32'h0,    1, 1, 0, 5'd3,  32'h22,        0);
        vecs[6]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 0, 5'd3,  32'h22,        1);
        vecs[7]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 1, 5'd5,  32'hDEADBEEF,  1);
        vecs[8]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 0, 5'd5,  32'hDEADBEEF,  0);
        // oldest-first: tie (pointer now favours B), then reloads while the other waits
        vecs[9]  = mk(1, 5'd8,  32'h80,        1, 5'd7,  32'h70,   1, 1, 0, 5'd5,  32'hDEADBEEF,  0);
        vecs[10] = mk(0, 5'd0,  32'h0,         1, 5'd10, 32'hA0,   0, 1, 0, 5'd5,  32'hDEADBEEF,  1);
        vecs[11] = mk(1, 5'd9,  32'h90,        1, 5'd11, 32'hB0,   1, 0, 1, 5'd7,  32'h70,        1);
        vecs[12] = mk(0, 5'd0,  32'h0,         1, 5'd11, 32'hB0,   0, 1, 1, 5'd8,  32'h80,        1);
        vecs[13] = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 0, 1, 5'd10, 32'hA0,        1);
        vecs[14] = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 1, 5'd9,  32'h90,        1);
        vecs[15] = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 1, 5'd11, 32'hB0,        1);
        vecs[16] = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 0, 5'd11, 32'hB0,        0);
        // x0 filter: A to Rd 0 is dropped, B right behind it
        vecs[17] = mk(1, 5'd0,  32'hFFFFFFFF,  0, 5'd0,  32'h0,    1, 1, 0, 5'd11, 32'hB0,        0);
        vecs[18] = mk(0, 5'd0,  32'h0,         1, 5'd1,  32'h1,    1, 1, 0, 5'd11, 32'hB0,        0);
        vecs[19] = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 0, 5'd11, 32'hB0,        1);
        vecs[20] = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 1, 5'd1,  32'h1,         1);
        vecs[21] = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    1, 1, 0, 5'd1,  32'h1,         0);

        // Reset values
        rst_n = 1'b0;
        drive_idle();
        #2;
        check("reset reg_wr", 32'(bus.Reg_Wr), 32'd0);
        check("reset rd_wr",  32'(bus.Rd_Wr),  32'd0);
        check("reset rd_in",  bus.Rd_In,       32'd0);
        check("reset busy",   32'(bus.Busy),   32'd0);
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
        #1;
        check("post-reset a_ready", 32'(bus.A_Ready), 32'd1);
        check("post-reset b_ready", 32'(bus.B_Ready), 32'd1);

        // Vector table: inputs driven just after a rising edge, outputs
        // checked on the falling edge of the same cycle
        for (int i = 0; i < NVEC; i++) begin
            @(posedge CLK);
            #1;
            bus.A_Valid = vecs[i].a_v; bus.A_Rd = vecs[i].a_rd; bus.A_Data = vecs[i].a_d;
            bus.B_Valid = vecs[i].b_v; bus.B_Rd = vecs[i].b_rd; bus.B_Data = vecs[i].b_d;
            @(negedge CLK);
            check($sformatf("vec%0d a_ready", i), 32'(bus.A_Ready), 32'(vecs[i].e_ar));
            check($sformatf("vec%0d b_ready", i), 32'(bus.B_Ready), 32'(vecs[i].e_br));
            check($sformatf("vec%0d reg_wr", i),  32'(bus.Reg_Wr),  32'(vecs[i].e_wr));
            check($sformatf("vec%0d rd_wr", i),   32'(bus.Rd_Wr),   32'(vecs[i].e_rdwr));
            check($sformatf("vec%0d rd_in", i),   bus.Rd_In,        vecs[i].e_rdin);
            check($sformatf("vec%0d busy", i),    32'(bus.Busy),    32'(vecs[i].e_busy));
        end

        // Streaming: both sources always valid; each source presents its next
        // entry once the current one has been accepted. Writes must come out
        // A0,B0,A1,B1,... one per cycle.
        a_cnt = 0;
        b_cnt = 0;
        for (int s = 0; s < 10; s++) begin
            @(posedge CLK);
            #1;
            bus.A_Valid = 1'b1; bus.A_Rd = 5'(16 + a_cnt); bus.A_Data = 32'(32'hA000 + a_cnt);
            bus.B_Valid = 1'b1; bus.B_Rd = 5'(24 + b_cnt); bus.B_Data = 32'(32'hB000 + b_cnt);
            @(negedge CLK);
            if (s == 0) begin
                check($sformatf("stream%0d a_ready", s), 32'(bus.A_Ready), 32'd1);
                check($sformatf("stream%0d b_ready", s), 32'(bus.B_Ready), 32'd1);
            end else begin
                check($sformatf("stream%0d a_ready", s), 32'(bus.A_Ready), 32'((s % 2) == 1));
                check($sformatf("stream%0d b_ready", s), 32'(bus.B_Ready), 32'((s % 2) == 0));
            end
            if (s >= 2) begin
                w = s - 2;
                exp_rd = ((w % 2) == 0) ? 5'(16 + w / 2) : 5'(24 + w / 2);
                exp_d  = ((w % 2) == 0) ? 32'(32'hA000 + w / 2) : 32'(32'hB000 + w / 2);
                check($sformatf("stream%0d reg_wr", s), 32'(bus.Reg_Wr), 32'd1);
                check($sformatf("stream%0d rd_wr", s),  32'(bus.Rd_Wr),  32'(exp_rd));
                check($sformatf("stream%0d rd_in", s),  bus.Rd_In,       exp_d);
            end else begin
                check($sformatf("stream%0d reg_wr", s), 32'(bus.Reg_Wr), 32'd0);
            end
            if (bus.A_Ready) a_cnt++;
            if (bus.B_Ready) b_cnt++;
        end

        // Reset abort while a write pulse is in flight
        #1;
        rst_n = 1'b0;
        #1;
        check("abort reg_wr", 32'(bus.Reg_Wr), 32'd0);
        check("abort busy",   32'(bus.Busy),   32'd0);
        check("abort rd_wr",  32'(bus.Rd_Wr),  32'd0);
        drive_idle();
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check($sformatf("after-abort%0d reg_wr", k), 32'(bus.Reg_Wr), 32'd0);
            check($sformatf("after-abort%0d busy", k),   32'(bus.Busy),   32'd0);
        end
        check("after-abort a_ready", 32'(bus.A_Ready), 32'd1);
        check("after-abort b_ready", 32'(bus.B_Ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
